// File: rtl/lsmask_pipe.sv
// lsmask_pipe: big-endian load/store byte-lane unit spanning the E and M stages.
//
// E stage (combinational): decodes MaskOpE and AddrLoE into RAM byte write strobes and
// lane-replicated store data, and flags misaligned accesses. Illegal op codes behave as
// "no access" and are remembered so M can report them.
// M stage: the op, byte offset and flags are registered from E; the raw RAM read data is
// then lane-selected and sign/zero-extended combinationally.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   StallM         hold the M-stage registers (takes priority over FlushE)
//   FlushE         squash the E instruction; a bubble enters M
//   MaskOpE        E op code (0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW,
//                  9 LWU, A LD, B SD)
//   AddrLoE        byte offset within the data word
//   StoreDataE     store operand (low bits)
//   ByteEnE        byte write strobes, bit NB-1 = byte offset 0
//   StoreDataOutE  store operand replicated across all lanes of its size
//   MisalignE      E op is misaligned
//   LoadDataM      raw RAM read data for the M instruction
//   LoadResultM    aligned, extended load result
//   MisalignM      registered misalign flag
//   IllegalOpM     registered illegal-op flag
//   MisalignCount  saturating count of misaligned ops entering M
module lsmask_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  localparam int NB = DATA_WIDTH / 8,
  localparam int AW = $clog2(NB)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallM,
  input  logic                  FlushE,
  input  logic [3:0]            MaskOpE,
  input  logic [AW-1:0]         AddrLoE,
  input  logic [DATA_WIDTH-1:0] StoreDataE,
  output logic [NB-1:0]         ByteEnE,
  output logic [DATA_WIDTH-1:0] StoreDataOutE,
  output logic                  MisalignE,
  input  logic [DATA_WIDTH-1:0] LoadDataM,
  output logic [DATA_WIDTH-1:0] LoadResultM,
  output logic                  MisalignM,
  output logic                  IllegalOpM,
  output logic [CNT_WIDTH-1:0]  MisalignCount
);

  // Access size in bytes; "no access" uses 1 so it is never misaligned.
  function automatic int op_size(logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8, 4'd9: return 4;
      4'd10, 4'd11:     return 8;
      default:          return 1;
    endcase
  endfunction

  function automatic logic op_is_load(logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd5) || op == 4'd9 || op == 4'd10;
  endfunction

  function automatic logic op_is_store(logic [3:0] op);
    return (op >= 4'd6 && op <= 4'd8) || op == 4'd11;
  endfunction

  // Doubleword-class ops (LWU/LD/SD) only exist on the 64-bit datapath.
  function automatic logic op_illegal(logic [3:0] op);
    return (op >= 4'd12) || (DATA_WIDTH == 32 && op >= 4'd9);
  endfunction

  function automatic logic op_signed(logic [3:0] op);
    return op >= 4'd1 && op <= 4'd3;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Take size bytes starting sh bytes up from the LSB and extend to the full width.
  function automatic logic [DATA_WIDTH-1:0] extract_load(logic [DATA_WIDTH-1:0] data,
                                                         int sh, int size, logic sext);
    logic [DATA_WIDTH-1:0] r;
    logic                  fill;
    r    = '0;
    fill = sext & data[(sh + size) * 8 - 1];
    for (int i = 0; i < NB; i++) begin
      if (i < size) r[i*8 +: 8] = data[(sh + i) * 8 +: 8];
      else          r[i*8 +: 8] = {8{fill}};
    end
    return r;
  endfunction

  // ---- E stage (p0): decode, strobes, store replication ----
  logic       ill_p0;
  logic [3:0] op_p0;
  logic       mis_p0;
  int         size_p0;
  int         off_p0;

  always_comb begin
    ill_p0        = op_illegal(MaskOpE);
    op_p0         = ill_p0 ? 4'd0 : MaskOpE;
    size_p0       = op_size(op_p0);
    off_p0        = int'(AddrLoE);
    mis_p0        = (off_p0 % size_p0) != 0;
    ByteEnE       = '0;
    StoreDataOutE = '0;
    for (int i = 0; i < NB; i++) begin
      // lane i holds big-endian byte offset NB-1-i
      if ((NB - 1 - i) >= off_p0 && (NB - 1 - i) < off_p0 + size_p0) ByteEnE[i] = 1'b1;
      StoreDataOutE[i*8 +: 8] = StoreDataE[(i % size_p0) * 8 +: 8];
    end
    if (!op_is_store(op_p0) || mis_p0 || StallM || FlushE) ByteEnE = '0;
  end

  assign MisalignE = mis_p0;

  // ---- E -> M boundary (p1): op/offset/flags, misalign counter ----
  logic [3:0]    op_p1;
  logic [AW-1:0] off_p1;
  logic          mis_p1;
  logic          ill_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_p1         <= 4'd0;
      off_p1        <= '0;
      mis_p1        <= 1'b0;
      ill_p1        <= 1'b0;
      MisalignCount <= '0;
    end else if (!StallM) begin
      if (FlushE) begin
        op_p1  <= 4'd0;
        off_p1 <= '0;
        mis_p1 <= 1'b0;
        ill_p1 <= 1'b0;
      end else begin
        op_p1  <= op_p0;
        off_p1 <= AddrLoE;
        mis_p1 <= mis_p0;
        ill_p1 <= ill_p0;
        if (mis_p0) MisalignCount <= sat_inc(MisalignCount);
      end
    end
  end

  assign MisalignM  = mis_p1;
  assign IllegalOpM = ill_p1;

  // ---- M stage (p1 comb): lane select and extend ----
  int size_m;
  int sh_m;

  always_comb begin
    size_m = op_size(op_p1);
    sh_m   = NB - int'(off_p1) - size_m;
    if (sh_m < 0) sh_m = 0;
    LoadResultM = '0;
    if (op_is_load(op_p1) && !mis_p1)
      LoadResultM = extract_load(LoadDataM, sh_m, size_m, op_signed(op_p1));
  end

endmodule

// File: tb/tb_lsmask_pipe.sv
module tb_lsmask_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, StallM, FlushE;
  logic [3:0]  MaskOpE;
  logic [1:0]  addr32;
  logic [2:0]  addr64;
  logic [31:0] sd32, ld32;
  logic [63:0] sd64, ld64;

  logic [3:0]  be32;  logic [31:0] sdo32, res32; logic mis32, misM32, illM32; logic [15:0] cnt32;
  logic [7:0]  be64;  logic [63:0] sdo64, res64; logic mis64, misM64, illM64; logic [1:0]  cnt64;

  int compared = 0;
  int mismatched = 0;

  lsmask_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u32 (
    .clk(clk), .rst(rst), .StallM(StallM), .FlushE(FlushE), .MaskOpE(MaskOpE),
    .AddrLoE(addr32), .StoreDataE(sd32), .ByteEnE(be32), .StoreDataOutE(sdo32),
    .MisalignE(mis32), .LoadDataM(ld32), .LoadResultM(res32), .MisalignM(misM32),
    .IllegalOpM(illM32), .MisalignCount(cnt32));

  lsmask_pipe #(.DATA_WIDTH(64), .CNT_WIDTH(2)) u64 (
    .clk(clk), .rst(rst), .StallM(StallM), .FlushE(FlushE), .MaskOpE(MaskOpE),
    .AddrLoE(addr64), .StoreDataE(sd64), .ByteEnE(be64), .StoreDataOutE(sdo64),
    .MisalignE(mis64), .LoadDataM(ld64), .LoadResultM(res64), .MisalignM(misM64),
    .IllegalOpM(illM64), .MisalignCount(cnt64));

  // Reference model state per width (index 0 = 32-bit, 1 = 64-bit)
  int     m_op[2], m_off[2];
  bit     m_mis[2], m_ill[2];
  longint m_cnt[2];
  longint cmax[2] = '{65535, 3};

  function automatic int sz(int op);
    case (op)
      1, 4, 6: return 1;
      2, 5, 7: return 2;
      3, 8, 9: return 4;
      10, 11:  return 8;
      default: return 1;
    endcase
  endfunction
  function automatic bit legal(int op, int nb);
    return (op <= 8) || (op <= 11 && nb == 8);
  endfunction
  function automatic bit is_store(int op); return op inside {6, 7, 8, 11}; endfunction
  function automatic bit is_load(int op);  return op inside {[1:5], 9, 10}; endfunction
  function automatic logic [63:0] bmask(int s);
    return (s >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * s)) - 64'd1);
  endfunction

  function automatic logic [63:0] exp_be(int nb, int eop, int a, bit st, bit fl);
    int s = sz(eop);
    if (is_store(eop) && (a % s) == 0 && !st && !fl)
      return ((64'd1 << s) - 64'd1) << (nb - a - s);
    return 64'd0;
  endfunction
  function automatic logic [63:0] exp_sdo(int nb, int eop, logic [63:0] sd);
    int s = sz(eop);
    logic [63:0] opnd = sd & bmask(s);
    logic [63:0] r = 64'd0;
    for (int k = 0; k < nb / s; k++) r |= opnd << (k * 8 * s);
    return r & bmask(nb);
  endfunction
  function automatic logic [63:0] exp_res(int nb, int mop, int moff, bit mmis, logic [63:0] ld);
    int s;
    logic [63:0] f;
    if (!is_load(mop) || mmis) return 64'd0;
    s = sz(mop);
    f = (ld >> ((nb - moff - s) * 8)) & bmask(s);
    if (mop inside {1, 2, 3} && f[8 * s - 1]) f |= ~bmask(s);
    return f & bmask(nb);
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_w(int w, logic [63:0] be, logic [63:0] sdo, logic mis,
                         logic [63:0] res, logic misM, logic illM, logic [63:0] cnt,
                         logic [63:0] ld);
    int nb  = w ? 8 : 4;
    int a   = w ? int'(addr64) : int'(addr32);
    int op  = int'(MaskOpE);
    int eop = legal(op, nb) ? op : 0;
    bit emis = (a % sz(eop)) != 0;
    string p = w ? "w64_" : "w32_";
    chk({p, "be"},  be, exp_be(nb, eop, a, StallM, FlushE));
    if (is_store(eop)) chk({p, "sdo"}, sdo, exp_sdo(nb, eop, w ? sd64 : {32'd0, sd32}));
    chk({p, "misE"}, {63'd0, mis}, {63'd0, emis});
    chk({p, "res"},  res, exp_res(nb, m_op[w], m_off[w], m_mis[w], ld));
    chk({p, "misM"}, {63'd0, misM}, {63'd0, m_mis[w]});
    chk({p, "illM"}, {63'd0, illM}, {63'd0, m_ill[w]});
    chk({p, "cnt"},  cnt, m_cnt[w]);
  endtask

  task automatic drive(int op, int a, logic [63:0] sd, logic [63:0] ld, bit st, bit fl);
    MaskOpE = op[3:0]; addr64 = a[2:0]; addr32 = a[1:0];
    sd64 = sd; sd32 = sd[31:0]; ld64 = ld; ld32 = ld[31:0];
    StallM = st; FlushE = fl;
    #4;
    check_w(0, {60'd0, be32}, {32'd0, sdo32}, mis32, {32'd0, res32}, misM32, illM32,
            {48'd0, cnt32}, {32'd0, ld32});
    check_w(1, {56'd0, be64}, sdo64, mis64, res64, misM64, illM64, {62'd0, cnt64}, ld64);
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_op[w] = 0; m_off[w] = 0; m_mis[w] = 0; m_ill[w] = 0; m_cnt[w] = 0;
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      for (int w = 0; w < 2; w++) begin
        int nb  = w ? 8 : 4;
        int a   = w ? int'(addr64) : int'(addr32);
        int op  = int'(MaskOpE);
        bit lg  = legal(op, nb);
        int eop = lg ? op : 0;
        bit mis = (a % sz(eop)) != 0;
        if (!StallM) begin
          if (FlushE) begin
            m_op[w] = 0; m_off[w] = 0; m_mis[w] = 0; m_ill[w] = 0;
          end else begin
            m_op[w] = eop; m_off[w] = a; m_mis[w] = mis; m_ill[w] = !lg;
            if (mis && m_cnt[w] < cmax[w]) m_cnt[w]++;
          end
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [63:0] ldx;
    rst = 1'b1; StallM = 0; FlushE = 0; MaskOpE = 0;
    addr32 = 0; addr64 = 0; sd32 = 0; sd64 = 0; ld32 = 0; ld64 = 0;
    model_reset();
    drive(3, 0, 64'h0, {$urandom, $urandom}, 0, 0);
    chk("rst_res32", {32'd0, res32}, 64'd0);
    chk("rst_cnt32", {48'd0, cnt32}, 64'd0);
    edge_step();
    rst = 1'b0;

    drive(6, 2, 64'hA5, 64'h0, 0, 0);
    chk("sb_be32", {60'd0, be32}, 64'h2);
    chk("sb_sdo32", {32'd0, sdo32}, 64'hA5A5A5A5);
    edge_step();
    drive(1, 3, 64'h0, 64'h0, 0, 0); edge_step();
    drive(4, 3, 64'h0, 64'h112233F0, 0, 0);
    chk("lb_res32", {32'd0, res32}, 64'hFFFFFFF0);
    edge_step();
    drive(2, 0, 64'h0, 64'h112233F0, 0, 0);
    chk("lbu_res32", {32'd0, res32}, 64'hF0);
    edge_step();
    drive(0, 0, 64'h0, 64'h112233F0, 0, 0);
    chk("lh_res32", {32'd0, res32}, 64'h1122);
    edge_step();

    drive(7, 1, 64'h1234, 64'h0, 0, 0);
    chk("sh_misE32", {63'd0, mis32}, 64'd1);
    chk("sh_be32", {60'd0, be32}, 64'd0);
    edge_step();
    drive(0, 0, 64'h0, 64'h0, 0, 0);
    chk("sh_misM32", {63'd0, misM32}, 64'd1);
    chk("sh_cnt32", {48'd0, cnt32}, 64'd1);
    edge_step();
    for (int i = 0; i < 4; i++) begin
      drive(7, 1, 64'h0, 64'h0, 0, 0); edge_step();
    end
    drive(0, 0, 64'h0, 64'h0, 0, 0);
    chk("sat_cnt64", {62'd0, cnt64}, 64'd3);
    chk("cnt32_5", {48'd0, cnt32}, 64'd5);
    edge_step();

    drive(9, 4, 64'h0, 64'h0, 0, 0); edge_step();
    drive(11, 0, 64'h1122334455667788, 64'h0102030480000000, 0, 0);
    chk("lwu_res64", res64, 64'h80000000);
    chk("lwu_ill32", {63'd0, illM32}, 64'd1);
    chk("sd_be64", {56'd0, be64}, 64'hFF);
    chk("sd_be32", {60'd0, be32}, 64'd0);
    edge_step();
    drive(10, 0, 64'h0, 64'h0, 0, 0);
    chk("sd_ill32", {63'd0, illM32}, 64'd1);
    edge_step();
    drive(0, 0, 64'h0, 64'h0, 0, 0);
    chk("ld_ill32", {63'd0, illM32}, 64'd1);
    edge_step();

    drive(7, 1, 64'h0, 64'h0, 0, 0); edge_step();
    drive(1, 0, 64'h0, 64'hFFFF, 1, 1);
    chk("stfl_be32", {60'd0, be32}, 64'd0);
    edge_step();
    drive(1, 0, 64'h0, 64'hFFFF, 1, 1);
    chk("stfl_hold32", {63'd0, misM32}, 64'd1);
    edge_step();
    drive(1, 0, 64'h0, 64'hFFFF, 0, 1); edge_step();
    drive(0, 0, 64'h0, 64'hFFFF_FFFF, 0, 0);
    chk("flush_misM32", {63'd0, misM32}, 64'd0);
    chk("flush_res32", {32'd0, res32}, 64'd0);
    edge_step();

    drive(7, 1, 64'h0, 64'h0, 0, 0); edge_step();
    drive(0, 0, 64'h0, {$urandom, $urandom}, 1, 0);
    chk("pre_rst_misM32", {63'd0, misM32}, 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_misM32", {63'd0, misM32}, 64'd0);
    chk("arst_misM64", {63'd0, misM64}, 64'd0);
    chk("arst_cnt32", {48'd0, cnt32}, 64'd0);
    chk("arst_cnt64", {62'd0, cnt64}, 64'd0);
    chk("arst_res64", res64, 64'd0);
    model_reset();
    #1;
    rst = 1'b0;
    edge_step();

    for (int i = 0; i < 400; i++) begin
      int op = $urandom_range(0, 15);
      int a  = $urandom_range(0, 7);
      if ($urandom_range(0, 2) != 0) a = a & ~(sz(op) - 1);
      ldx = {$urandom, $urandom};
      drive(op, a, {$urandom, $urandom}, ldx, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0);
      edge_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
